op_chain_mac: RTL and testbench

- Parametrised successor to the fixed (a*b)*(c*d) operation block.
- Accepts NUM_OPS unsigned WIDTH-bit operands through a strobe/busy handshake.
- Computes, per transaction, either the full chain product or the sum of pairwise products.
- Time-shares one internal sequential shift-add multiplier and returns the truncated WIDTH-bit result through a strobe/busy output handshake to the downstream output module.

---
 rtl/op_chain_pkg.sv | 21 ++
 rtl/seq_mul_unit.sv | 45 ++++
 rtl/op_chain_mac.sv | 203 ++++++++++++++++++++
 tb/tb_op_chain_mac.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_chain_pkg.sv
// Shared FSM encoding, mode constants and multiply-count helper for op_chain_mac.
package op_chain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MSTART,
        MWAIT,
        ACCUM,
        OUTPUT
    } state_t;

    localparam logic MODE_PROD = 1'b0;
    localparam logic MODE_SOP  = 1'b1;

    // Multiplies per transaction: chain needs num_ops-1, sum of pairs needs num_ops/2.
    function automatic int unsigned num_mults(input int unsigned num_ops, input logic mode);
        return (mode == MODE_SOP) ? (num_ops / 2) : (num_ops - 1);
    endfunction

endpackage

// File: rtl/seq_mul_unit.sv
// Sequential shift-add unsigned multiplier: WIDTH step cycles after start, full 2*WIDTH product.
module seq_mul_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done_c,
    output logic [2*WIDTH-1:0] prod
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            prod     <= '0;
        end else if (start) begin
            mcand_q  <= PW'(a);
            mplier_q <= b;
            cnt_q    <= CNT_W'(WIDTH);
            prod     <= '0;
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                prod <= prod + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

    // High during the cycle whose closing edge performs the final step.
    assign done_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/op_chain_mac.sv
// Parametrised chain-product / sum-of-pairwise-products engine on one shared sequential multiplier.
// Optional build macro OP_CHAIN_OVF_FLAG_EN adds the sticky overflow output ovf.
module op_chain_mac
    import op_chain_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_OPS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    input  logic                     in_mode,
    input  logic                     in_stb,
    output logic                     busy,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_stb,
`ifdef OP_CHAIN_OVF_FLAG_EN
    output logic                     ovf,
`endif
    input  logic                     out_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_OPS);
    localparam int unsigned PW    = 2 * WIDTH;

    state_t               state_q, state_d;
    logic                 busy_d;
    logic                 out_stb_d;
    logic [WIDTH-1:0]     out_result_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [WIDTH-1:0]     ops_q [NUM_OPS];
    logic [WIDTH-1:0]     ops_d [NUM_OPS];

    logic                 mul_start_c;
    logic [WIDTH-1:0]     mul_a_c;
    logic [WIDTH-1:0]     mul_b_c;
    logic                 mul_done_c;
    logic [PW-1:0]        mul_prod;
    logic [WIDTH-1:0]     prod_lo_c;
    logic [WIDTH-1:0]     acc_next_c;
    logic                 last_c;

    assign prod_lo_c = mul_prod[WIDTH-1:0];

`ifdef OP_CHAIN_OVF_FLAG_EN
    logic                 flag_q, flag_d;
    logic                 ovf_d;
    logic [WIDTH:0]       sum_c;
    logic                 ovf_hit_c;

    assign sum_c      = (WIDTH+1)'(acc_q) + (WIDTH+1)'(prod_lo_c);
    assign ovf_hit_c  = (|mul_prod[PW-1:WIDTH]) | ((mode_q == MODE_SOP) & sum_c[WIDTH]);
    assign acc_next_c = (mode_q == MODE_SOP) ? sum_c[WIDTH-1:0] : prod_lo_c;
`else
    logic [WIDTH-1:0]     sum_c;
    logic                 unused_prod_hi;

    assign sum_c          = acc_q + prod_lo_c;
    assign unused_prod_hi = ^mul_prod[PW-1:WIDTH];
    assign acc_next_c     = (mode_q == MODE_SOP) ? sum_c : prod_lo_c;
`endif

    assign last_c = ((32'(cnt_q) + 32'd1) == num_mults(NUM_OPS, mode_q));

    seq_mul_unit #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start_c),
        .a      (mul_a_c),
        .b      (mul_b_c),
        .done_c (mul_done_c),
        .prod   (mul_prod)
    );

    // Next-state, datapath and output logic.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy;
        out_stb_d    = out_stb;
        out_result_d = out_result;
        acc_d        = acc_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        ops_d        = ops_q;
        mul_start_c  = 1'b0;
`ifdef OP_CHAIN_OVF_FLAG_EN
        flag_d       = flag_q;
        ovf_d        = ovf;
`endif
        if (mode_q == MODE_SOP) begin
            mul_a_c = ops_q[idx_q];
            mul_b_c = ops_q[idx_q + IDX_W'(1)];
        end else begin
            mul_a_c = acc_q;
            mul_b_c = ops_q[idx_q];
        end

        case (state_q)
            IDLE: begin
                if (in_stb) begin
                    busy_d  = 1'b1;
                    mode_d  = in_mode;
                    for (int i = 0; i < int'(NUM_OPS); i++) begin
                        ops_d[i] = in_ops[i*WIDTH +: WIDTH];
                    end
`ifdef OP_CHAIN_OVF_FLAG_EN
                    flag_d  = 1'b0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d = '0;
                if (mode_q == MODE_SOP) begin
                    acc_d = '0;
                    idx_d = '0;
                end else begin
                    acc_d = ops_q[0];
                    idx_d = IDX_W'(1);
                end
                state_d = MSTART;
            end
            MSTART: begin
                mul_start_c = 1'b1;
                state_d     = MWAIT;
            end
            MWAIT: begin
                if (mul_done_c) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_next_c;
                cnt_d = cnt_q + IDX_W'(1);
`ifdef OP_CHAIN_OVF_FLAG_EN
                flag_d = flag_q | ovf_hit_c;
`endif
                if (last_c) begin
                    out_result_d = acc_next_c;
                    out_stb_d    = 1'b1;
`ifdef OP_CHAIN_OVF_FLAG_EN
                    ovf_d        = flag_q | ovf_hit_c;
`endif
                    state_d      = OUTPUT;
                end else begin
                    idx_d   = idx_q + ((mode_q == MODE_SOP) ? IDX_W'(2) : IDX_W'(1));
                    state_d = MSTART;
                end
            end
            OUTPUT: begin
                if (!out_busy) begin
                    out_stb_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            out_stb    <= 1'b0;
            out_result <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            mode_q     <= MODE_PROD;
            for (int i = 0; i < int'(NUM_OPS); i++) begin
                ops_q[i] <= '0;
            end
`ifdef OP_CHAIN_OVF_FLAG_EN
            flag_q     <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            busy       <= busy_d;
            out_stb    <= out_stb_d;
            out_result <= out_result_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            ops_q      <= ops_d;
`ifdef OP_CHAIN_OVF_FLAG_EN
            flag_q     <= flag_d;
            ovf        <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_op_chain_mac.sv
// Scoreboard bench for op_chain_mac (WIDTH=16, NUM_OPS=4); checks ovf when OP_CHAIN_OVF_FLAG_EN is defined.
module tb_op_chain_mac;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct packed {
        logic          ovf;
        logic [W-1:0]  res;
    } exp_t;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] in_ops;
    logic           in_mode;
    logic           in_stb;
    logic           busy;
    logic [W-1:0]   out_result;
    logic           out_stb;
    logic           out_busy;
`ifdef OP_CHAIN_OVF_FLAG_EN
    logic           ovf;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    op_chain_mac #(
        .WIDTH   (W),
        .NUM_OPS (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_ops     (in_ops),
        .in_mode    (in_mode),
        .in_stb     (in_stb),
        .busy       (busy),
        .out_result (out_result),
        .out_stb    (out_stb),
`ifdef OP_CHAIN_OVF_FLAG_EN
        .ovf        (ovf),
`endif
        .out_busy   (out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: unsigned arithmetic on full products, truncated to W bits.
    function automatic exp_t model(input logic [N*W-1:0] ops, input logic mode);
        exp_t         e;
        logic [2*W-1:0] p;
        logic [W:0]     s;
        logic [W-1:0]   acc;
        logic           o;
        o = 1'b0;
        if (mode == 1'b0) begin
            acc = ops[0 +: W];
            for (int i = 1; i < N; i++) begin
                p   = (2*W)'(acc) * (2*W)'(ops[i*W +: W]);
                o   = o | (p[2*W-1:W] != '0);
                acc = p[W-1:0];
            end
        end else begin
            acc = '0;
            for (int i = 0; i < N; i += 2) begin
                p   = (2*W)'(ops[i*W +: W]) * (2*W)'(ops[(i+1)*W +: W]);
                o   = o | (p[2*W-1:W] != '0);
                s   = (W+1)'(acc) + (W+1)'(p[W-1:0]);
                o   = o | s[W];
                acc = s[W-1:0];
            end
        end
        e.res = acc;
        e.ovf = o;
        return e;
    endfunction

    function automatic int exp_lat(input logic mode);
        int m;
        m = (mode == 1'b0) ? (N - 1) : (N / 2);
        return 1 + m * (W + 2);
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        if (sb.size() > 0) e = sb.pop_front();
        else e = 'x;
        return e;
    endfunction

    // Drive one transaction through the accept edge; leaves time at #1 after that edge.
    task automatic start_txn(input logic [N*W-1:0] ops, input logic mode);
        in_ops  = ops;
        in_mode = mode;
        sb.push_back(model(ops, mode));
        in_stb  = 1'b1;
        @(posedge clk);
        #1;
        in_stb  = 1'b0;
    endtask

    // Count edges until out_stb is seen; -1 on timeout.
    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (out_stb !== 1'b1 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = (out_stb === 1'b1) ? n : -1;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_stb = 1'b0; out_busy = 1'b0; in_ops = '0; in_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (out_stb !== 1'b0) begin failures++; $display("FAIL reset_out_stb: got %b want 0", out_stb); end
        checks++; if (out_result !== '0) begin failures++; $display("FAIL reset_result: got %h want 0000", out_result); end
`ifdef OP_CHAIN_OVF_FLAG_EN
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One unstalled transaction: accept, latency, result, take.
    task automatic run_simple(input string nm, input logic [N*W-1:0] ops, input logic mode);
        int   lat;
        exp_t e;
        start_txn(ops, mode);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy_accept: got %b want 1", nm, busy); end
        wait_out(lat);
        checks++; if (lat != exp_lat(mode)) begin failures++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, exp_lat(mode)); end
        e = pop_exp();
        checks++; if (out_result !== e.res) begin failures++; $display("FAIL %s_result: got %h want %h", nm, out_result, e.res); end
`ifdef OP_CHAIN_OVF_FLAG_EN
        checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL %s_ovf: got %b want %b", nm, ovf, e.ovf); end
`endif
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_stb !== 1'b0) begin
            failures++; $display("FAIL %s_take: busy=%b out_stb=%b want 0/0", nm, busy, out_stb);
        end
    endtask

    task automatic test_chain;
        run_simple("chain", {16'd5, 16'd4, 16'd3, 16'd2}, 1'b0);
    endtask

    task automatic test_sop;
        run_simple("sop", {16'd5, 16'd4, 16'd3, 16'd2}, 1'b1);
    endtask

    task automatic test_wrap;
        run_simple("wrap_chain", {16'd1, 16'd1, 16'h0100, 16'h0100}, 1'b0);
        run_simple("wrap_sop", {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1'b1);
    endtask

    task automatic test_backpressure;
        int   lat;
        exp_t e;
        out_busy = 1'b1;
        start_txn({16'd9, 16'd7, 16'd5, 16'd3}, 1'b1);
        wait_out(lat);
        checks++; if (lat != exp_lat(1'b1)) begin failures++; $display("FAIL bp_latency: got %0d want %0d", lat, exp_lat(1'b1)); end
        e = pop_exp();
        for (int k = 0; k < 10; k++) begin
            in_stb = (k % 3 == 0);
            @(posedge clk);
            #1;
            checks++;
            if (out_stb !== 1'b1 || busy !== 1'b1 || out_result !== e.res) begin
                failures++;
                $display("FAIL bp_hold_%0d: out_stb=%b busy=%b result=%h want 1/1/%h", k, out_stb, busy, out_result, e.res);
            end
        end
        in_stb   = 1'b0;
        out_busy = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_stb !== 1'b0) begin
            failures++; $display("FAIL bp_take: busy=%b out_stb=%b want 0/0", busy, out_stb);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_no_second_accept: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        start_txn({16'd3, 16'd2, 16'd6, 16'd4}, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_stb !== 1'b0 || out_result !== '0) begin
            failures++; $display("FAIL rst_mid_async: busy=%b out_stb=%b result=%h want 0/0/0000", busy, out_stb, out_result);
        end
        sb.delete();
        #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_stb !== 1'b0) begin
            failures++; $display("FAIL rst_mid_discard: busy=%b out_stb=%b want 0/0", busy, out_stb);
        end
        run_simple("rst_resume", {16'd7, 16'd1, 16'd1, 16'd1}, 1'b0);
    endtask

    task automatic test_back_to_back;
        int   lat;
        exp_t e;
        in_ops  = {16'd11, 16'd3, 16'd2, 16'd9};
        in_mode = 1'b0;
        sb.push_back(model(in_ops, in_mode));
        in_stb  = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_first_accept: busy=%b want 1", busy); end
        in_ops  = {16'd20, 16'd10, 16'd6, 16'd8};
        in_mode = 1'b1;
        sb.push_back(model(in_ops, in_mode));
        wait_out(lat);
        checks++; if (lat != exp_lat(1'b0)) begin failures++; $display("FAIL b2b_lat1: got %0d want %0d", lat, exp_lat(1'b0)); end
        e = pop_exp();
        checks++; if (out_result !== e.res) begin failures++; $display("FAIL b2b_result1: got %h want %h", out_result, e.res); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_stb !== 1'b0) begin
            failures++; $display("FAIL b2b_take1: busy=%b out_stb=%b want 0/0", busy, out_stb);
        end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept: busy=%b want 1", busy); end
        in_stb = 1'b0;
        wait_out(lat);
        checks++; if (lat != exp_lat(1'b1)) begin failures++; $display("FAIL b2b_lat2: got %0d want %0d", lat, exp_lat(1'b1)); end
        e = pop_exp();
        checks++; if (out_result !== e.res) begin failures++; $display("FAIL b2b_result2: got %h want %h", out_result, e.res); end
`ifdef OP_CHAIN_OVF_FLAG_EN
        checks++; if (ovf !== e.ovf) begin failures++; $display("FAIL b2b_ovf2: got %b want %b", ovf, e.ovf); end
`endif
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_stb !== 1'b0) begin
            failures++; $display("FAIL b2b_take2: busy=%b out_stb=%b want 0/0", busy, out_stb);
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_scoreboard: %0d left want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_chain();
        test_sop();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
